// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetch queue between the pipeline fetch port and the ITCM.
// Optional hit/redirect counters are built when PREFETCH_STATS_EN is defined.
module ifetch_prefetch #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic [31:0]       cpu_rd_data,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_waitrequest
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    STREAM
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   fifo_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   head_addr, fetch_ptr;
  logic [ADDR_W-1:0]   cpu_word;
  logic                addr_match;
  logic                hit, redirect, push;
  logic                unused_addr_bits;

  // Byte offset within a word is don't-care for fetches.
  assign cpu_word         = {cpu_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign addr_match       = (cpu_word == head_addr);

  assign mem_addr    = fetch_ptr;
  assign cpu_rd_data = (count != '0) ? fifo_q[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, ITCM strobe and the combinational hit handshake.
  always_comb begin
    state_nxt       = state;
    mem_rd          = 1'b0;
    cpu_waitrequest = 1'b1;
    hit             = 1'b0;
    redirect        = 1'b0;
    push            = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_rd) begin
          redirect  = 1'b1;
          state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        mem_rd = 1'b1;
        if (!mem_waitrequest) begin
          push      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        mem_rd = (count < CNT_W'(DEPTH));
        if (cpu_rd && !addr_match) begin
          // Non-sequential fetch: any beat landing this cycle is stale.
          redirect  = 1'b1;
          state_nxt = REDIRECT;
        end else begin
          push = mem_rd && !mem_waitrequest;
          if (cpu_rd && (count != '0)) begin
            hit             = 1'b1;
            cpu_waitrequest = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Queue pointers and the head/fetch address pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_addr <= '0;
      fetch_ptr <= '0;
    end else if (redirect) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_addr <= cpu_word;
      fetch_ptr <= cpu_word;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        fetch_ptr <= fetch_ptr + ADDR_W'(4);
      end
      if (hit) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        head_addr <= head_addr + ADDR_W'(4);
      end
      count <= count + CNT_W'(push) - CNT_W'(hit);
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr] <= mem_rd_data;
  end

`ifdef PREFETCH_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (hit && !(&stat_hits))        stat_hits   <= stat_hits + 32'(1);
      if (redirect && !(&stat_misses)) stat_misses <= stat_misses + 32'(1);
    end
  end
`endif

endmodule
